// File: rtl/data_memory_ctrl.sv
// MIPS data memory controller: byte/half/word loads and stores with extension,
// alignment/range checking and a fixed-latency Ready/Busy handshake.
module data_memory_ctrl #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          MEMORY_DEPTH = 256,
    parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
    parameter int          WAIT_STATES  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    input  logic [DATA_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Ready,
    output logic                  Busy,
    output logic                  Error,
    output logic [1:0]            o_dbg_state
);
    localparam int AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic        r_rd, r_wr, r_uns, r_err;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [31:0] r_mem [MEMORY_DEPTH];

    // In IDLE the live inputs are the request, so a zero-wait access can
    // complete on its own accept edge; afterwards the latched copy is used.
    logic        w_idle, w_accept, w_enter_done, w_we, w_err;
    logic        w_op_rd, w_op_wr, w_op_uns;
    logic [1:0]  w_size, w_lane;
    logic [31:0] w_addr, w_wdata, w_off, w_word, w_load, w_wd;
    logic [3:0]  w_be;
    logic [AW-1:0] w_idx;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle && (MemRead || MemWrite);
    assign w_op_rd  = w_idle ? MemRead   : r_rd;
    assign w_op_wr  = w_idle ? MemWrite  : r_wr;
    assign w_op_uns = w_idle ? Unsigned  : r_uns;
    assign w_size   = w_idle ? Size      : r_size;
    assign w_addr   = w_idle ? Address   : r_addr;
    assign w_wdata  = w_idle ? WriteData : r_wdata;

    assign w_off  = w_addr - BASE_ADDR;
    assign w_idx  = w_off[AW+1:2];
    assign w_lane = w_addr[1:0];

    always_comb begin
        w_err = 1'b0;
        if (w_op_rd && w_op_wr) w_err = 1'b1;
        case (w_size)
            2'b01:   if (w_addr[0]) w_err = 1'b1;
            2'b10:   if (w_addr[1:0] != 2'b00) w_err = 1'b1;
            2'b11:   w_err = 1'b1;
            default: ;
        endcase
        if (w_addr < BASE_ADDR) w_err = 1'b1;
        if ((w_off >> 2) >= 32'(MEMORY_DEPTH)) w_err = 1'b1;
    end

    assign w_enter_done = reset && ((w_accept && (WAIT_STATES == 0)) ||
                                    ((r_state == S_WAIT) && (r_cnt == 4'd0)));
    assign w_we = w_enter_done && w_op_wr && !w_op_rd && !w_err;

    always_comb begin
        w_be = 4'b0000;
        w_wd = w_wdata;
        case (w_size)
            2'b00: begin
                w_be = 4'b0001 << w_lane;
                w_wd = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wd = {2{w_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
            end
        end
    end

    assign w_word = r_mem[w_idx];
    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        case (w_lane)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    always_comb begin
        case (w_size)
            2'b00:   w_load = {{24{!w_op_uns && w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{!w_op_uns && w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_rd    <= MemRead;
                r_wr    <= MemWrite;
                r_uns   <= Unsigned;
                r_size  <= Size;
                r_addr  <= Address;
                r_wdata <= WriteData;
                r_cnt   <= CNT_LOAD;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_done) begin
                r_err   <= w_err;
                r_rdata <= (w_op_rd && !w_op_wr && !w_err) ? w_load : 32'd0;
            end
        end
    end

    assign Ready       = (r_state == S_DONE);
    assign Busy        = (r_state != S_IDLE);
    assign Error       = Ready && r_err;
    assign ReadData    = r_rdata;
    assign o_dbg_state = r_state;
endmodule
